inst_cache: RTL

Direct-mapped, read-only instruction cache. It is the responder on the fetch-side cache interface: it answers `inst_read`/`inst_addr` with `inst_resp`/`inst_rdata`. A hit is answered combinationally in the same cycle, so the fetch stage's stall (`!inst_resp`) clears immediately. A miss is filled from physical memory one 256-bit line at a time through the cacheline adaptor.

---
 rtl/inst_cache_pkg.sv | 14 +
 rtl/rv32i_types.sv | 6 +
 rtl/inst_cache_array.sv | 58 +++++
 rtl/inst_cache.sv | 136 +++++++++++++
 4 files changed

// File: rtl/inst_cache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package inst_cache_pkg;

  localparam int unsigned LINE_WIDTH   = 256;
  localparam int unsigned OFFSET_WIDTH = 5;

  typedef logic [LINE_WIDTH-1:0] cache_line_t;

  typedef enum logic {
    IDLE,
    FETCH
  } inst_cache_state_t;

endpackage

// File: rtl/rv32i_types.sv
// Shared RV32I scalar types used across the core and its caches.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

endpackage

// File: rtl/inst_cache_array.sv
// Flop-based valid/tag/data storage for inst_cache: async read, sync write,
// valid bits cleared by the asynchronous active-low reset.
module inst_cache_array
  import inst_cache_pkg::*;
#(
  parameter int unsigned S_INDEX = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [S_INDEX-1:0]               rd_index,
  output logic                             rd_valid,
  output logic [31-OFFSET_WIDTH-S_INDEX:0] rd_tag,
  output logic [LINE_WIDTH-1:0]            rd_line,
  input  logic                             we,
  input  logic [S_INDEX-1:0]               wr_index,
  input  logic [31-OFFSET_WIDTH-S_INDEX:0] wr_tag,
  input  logic [LINE_WIDTH-1:0]            wr_line
);

  localparam int unsigned Sets = 1 << S_INDEX;
  localparam int unsigned TagW = 32 - OFFSET_WIDTH - S_INDEX;

  logic [Sets-1:0] valid_q, valid_d;
  logic [TagW-1:0] tag_q  [Sets];
  logic [TagW-1:0] tag_d  [Sets];
  cache_line_t     data_q [Sets];
  cache_line_t     data_d [Sets];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (we) begin
      valid_d[wr_index] = 1'b1;
      tag_d[wr_index]   = wr_tag;
      data_d[wr_index]  = wr_line;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tags and data are not reset; the valid bit guards them.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: combinational hit, one-line fills.
// Optional saturating hit/miss counters are built when INST_CACHE_PERF_EN is defined.
module inst_cache
  import inst_cache_pkg::*;
  import rv32i_types::*;
#(
  parameter int unsigned S_INDEX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_read,
  input  logic [31:0]           inst_addr,
  output logic                  inst_resp,
  output logic [31:0]           inst_rdata,
  output logic                  pmem_read,
  output logic [31:0]           pmem_address,
  input  logic                  pmem_resp,
  input  logic [LINE_WIDTH-1:0] pmem_rdata
`ifdef INST_CACHE_PERF_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int unsigned TagW = 32 - OFFSET_WIDTH - S_INDEX;

  inst_cache_state_t state_q, state_d;
  rv32i_word         miss_addr_q, miss_addr_d;

  logic [S_INDEX-1:0] addr_index;
  logic [TagW-1:0]    addr_tag;
  logic [2:0]         word_sel;
  logic               rd_valid;
  logic [TagW-1:0]    rd_tag;
  cache_line_t        rd_line;
  logic               hit;
  logic               idle_hit;
  logic               fill_we;
  logic               unused_addr;

  assign addr_index  = inst_addr[OFFSET_WIDTH +: S_INDEX];
  assign addr_tag    = inst_addr[31 -: TagW];
  assign word_sel    = inst_addr[4:2];
  assign unused_addr = ^inst_addr[1:0];

  inst_cache_array #(
    .S_INDEX (S_INDEX)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (addr_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .we       (fill_we),
    .wr_index (miss_addr_q[OFFSET_WIDTH +: S_INDEX]),
    .wr_tag   (miss_addr_q[31 -: TagW]),
    .wr_line  (pmem_rdata)
  );

  assign hit          = inst_read && rd_valid && (rd_tag == addr_tag);
  assign idle_hit     = (state_q == IDLE) && hit;
  assign pmem_address = miss_addr_q;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    inst_resp   = 1'b0;
    inst_rdata  = '0;
    pmem_read   = 1'b0;
    fill_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          inst_resp  = 1'b1;
          inst_rdata = rd_line[{word_sel, 5'b0} +: 32];
        end else if (inst_read) begin
          miss_addr_d = {inst_addr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
          state_d     = FETCH;
        end
      end
      FETCH: begin
        // Fill always completes regardless of what fetch does meanwhile.
        pmem_read = 1'b1;
        if (pmem_resp) begin
          fill_we = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

`ifdef INST_CACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (idle_hit && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if ((state_q == IDLE) && (state_d == FETCH) && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  logic unused_hit;
  assign unused_hit = idle_hit;
`endif

endmodule
